otsu_frame_ctrl: RTL and testbench
==================================

Name: otsu_frame_ctrl

Overview:
- Frame scheduler in front of the Otsu histogram datapath. Admits one video frame at a time into the histogram engine, with programmable frame skipping.
- Blocks all vs/hs/de activity while the engine is reading out and clearing its RAMs.
- Tags each candidate-threshold result pulse with its threshold index.
- Reports frame completion, and flags count and timeout errors.

Parameters:
- NUM_CAND, 128, expected dsp_vld pulses per admitted frame
- TIMEOUT, 20000, maximum cycles allowed in PROC before abort
- TO_W, 16, width of the timeout counter (must satisfy TIMEOUT < 2^TO_W)

Ports:
- clock  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  admit frames while high
- cfg_skip  in  4  frames to drop between admitted frames
- err_clr  in  1  clears the sticky error flags
- vs_i, hs_i, de_i  in  1 each  source timing
- gray_i  in  8  source pixel
- vs_o, hs_o, de_o  out  1 each  gated timing, to the histogram engine
- gray_o  out  8  pixel delayed one cycle, to the histogram engine
- dsp_vld  in  1  candidate result strobe from the histogram engine
- finish_clear  in  1  last RAM-clear cycle from the histogram engine
- cand_vld  out  1  equals dsp_vld while in PROC, else 0
- cand_idx  out  7  threshold index for the current dsp_vld
- frame_done  out  1  one-cycle pulse per completed frame
- frame_cnt  out  16  completed-frame counter, wraps modulo 2^16
- busy  out  1  high in PASS or PROC
- err_count  out  1  sticky: wrong dsp_vld count
- err_timeout  out  1  sticky: PROC timeout

Behaviour:
Reset:
- All outputs are 0 on reset; state=IDLE.
- Reset mid-frame forces vs_o/hs_o/de_o low immediately (asynchronous).

Gating pipeline:
- vs_o, hs_o, de_o, gray_o are registered: one-cycle latency from the inputs.
- Timing outputs equal the delayed inputs when the gate is open, else 0. gray_o is never gated.

Edge detect:
- vs_rise = vs_i & ~vs_d; vs_fall = ~vs_i & vs_d (vs_d is vs_i registered).

States:
- IDLE: gate closed. When enable=1, load skip_cnt<=cfg_skip and go to ARM.
- ARM: gate closed.
  - enable=0 -> IDLE.
  - vs_rise with skip_cnt>0 -> skip_cnt decrements, stay in ARM.
  - vs_rise with skip_cnt==0 -> PASS, gate opens in the same cycle, so vs_o rises one cycle after vs_i.
  - A frame already in progress when ARM is entered (vs_i high) is never admitted partially.
- PASS: gate open. On vs_fall go to PROC; the gate closes from the next cycle, so the falling edge of vs_o is still delivered.
- PROC:
  - Gate closed; vs_rise events are ignored, and those frames are dropped.
  - cand_cnt (8 bits) clears on entry and increments on each dsp_vld; cand_idx = cand_cnt[6:0], valid in the same cycle as dsp_vld.
  - to_cnt clears on entry and increments every cycle.
  - On finish_clear: if cand_cnt != NUM_CAND, set err_count. Then go to DONE.
  - If to_cnt reaches TIMEOUT-1 without finish_clear: set err_timeout and go to ARM (or IDLE if enable=0), with no frame_done.
- DONE: one cycle.
  - frame_done=1 and frame_cnt increments.
  - Reload skip_cnt<=cfg_skip.
  - Go to ARM if enable=1, else IDLE.
- enable=0 during PASS or PROC does not abort; the frame completes and the block then enters IDLE.

Outputs and errors:
- busy = (state==PASS)|(state==PROC).
- err_clr clears both sticky flags. If a set condition occurs in the same cycle, set wins.
- dsp_vld or finish_clear outside PROC: ignored, with no state change and no count.

Test Plan:
- enable=1, cfg_skip=0, three 4x4-pixel frames back-to-back with a blanking gap shorter than readout. Engine model emits 128 dsp_vld then finish_clear. -> Frame 1 passes with 1-cycle delay; frame 2 is fully blocked (vs_o stays 0); frame 3 passes. frame_cnt=2, err flags 0.
- cfg_skip=2, five frames, engine responds instantly. -> Frames 1, 4 admitted; frames 2, 3, 5 blocked. frame_cnt=2.
- In PROC, 128 dsp_vld pulses spaced 128 cycles apart. -> cand_idx = 0, 1, …, 127 coincident with each pulse; frame_done 1 cycle after finish_clear.
- Model emits 127 dsp_vld then finish_clear. -> err_count=1, frame_done still pulses. err_clr=1 -> err_count=0.
- No finish_clear after vs falls. -> After exactly 20000 PROC cycles, err_timeout=1, state ARM, frame_cnt unchanged, and the next frame is admitted.
- enable rises while vs_i is high; separately, rst_n is pulsed low mid-PASS. -> The partial frame is not admitted (vs_o stays 0 until the next vs rise). On reset, all outputs are 0 immediately and frame_cnt=0.

Source files
------------

// File: rtl/otsu_frame_ctrl_if.sv
// Video and histogram-engine signal bundle for otsu_frame_ctrl.
//   slave  : the frame controller (takes source timing and engine strobes,
//            drives gated timing and tagged candidate strobes)
//   master : the source/engine side (testbench or surrounding system)
// Signals: vs_i/hs_i/de_i/gray_i source timing and pixel,
//          vs_o/hs_o/de_o/gray_o timing and pixel toward the engine,
//          dsp_vld/finish_clear engine strobes, cand_vld/cand_idx tagged result.
interface otsu_frame_ctrl_if;
    logic       vs_i;
    logic       hs_i;
    logic       de_i;
    logic [7:0] gray_i;
    logic       vs_o;
    logic       hs_o;
    logic       de_o;
    logic [7:0] gray_o;
    logic       dsp_vld;
    logic       finish_clear;
    logic       cand_vld;
    logic [6:0] cand_idx;

    modport slave (
        input  vs_i, hs_i, de_i, gray_i, dsp_vld, finish_clear,
        output vs_o, hs_o, de_o, gray_o, cand_vld, cand_idx
    );

    modport master (
        output vs_i, hs_i, de_i, gray_i, dsp_vld, finish_clear,
        input  vs_o, hs_o, de_o, gray_o, cand_vld, cand_idx
    );
endinterface

// File: rtl/otsu_frame_ctrl.sv
// Frame scheduler in front of the Otsu histogram engine.
// Admits one frame at a time (with programmable skipping), blocks timing while
// the engine reads out and clears, tags candidate strobes with their index,
// counts completed frames and flags count/timeout errors.
// Ports:
//   clock, rst_n      clock, asynchronous active-low reset
//   enable            admit frames while high
//   cfg_skip          frames dropped between admitted frames
//   err_clr           clears the sticky error flags
//   vid               video/engine bundle (slave side)
//   frame_done        one-cycle pulse per completed frame
//   frame_cnt         completed-frame counter (wraps)
//   busy              high while passing or processing a frame
//   err_count         sticky: wrong number of candidate strobes
//   err_timeout       sticky: engine never signalled finish_clear
module otsu_frame_ctrl #(
    parameter int unsigned NUM_CAND = 128,
    parameter int unsigned TIMEOUT  = 20000,
    parameter int unsigned TO_W     = 16
) (
    input  logic                clock,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [3:0]          cfg_skip,
    input  logic                err_clr,
    otsu_frame_ctrl_if.slave    vid,
    output logic                frame_done,
    output logic [15:0]         frame_cnt,
    output logic                busy,
    output logic                err_count,
    output logic                err_timeout
);
    typedef enum logic [2:0] {IDLE, ARM, PASS, PROC, DONE} state_t;

    state_t            state, state_nx;
    logic              vs_d;
    logic              vs_rise, vs_fall;
    logic              gate_open;
    logic [3:0]        skip_cnt;
    logic [7:0]        cand_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              timeout_hit;
    logic              proc_entry;

    assign vs_rise     = vid.vs_i & ~vs_d;
    assign vs_fall     = ~vid.vs_i & vs_d;
    assign timeout_hit = (to_cnt == TO_W'(TIMEOUT - 1));
    assign proc_entry  = (state == PASS) && vs_fall;

    // Gate opens in the admitting ARM cycle so vs_o trails vs_i by exactly one
    // cycle; it stays open through the PASS cycle that sees vs fall so the
    // falling edge of vs_o is still delivered.
    always_comb begin
        state_nx  = state;
        gate_open = 1'b0;
        case (state)
            IDLE: if (enable) state_nx = ARM;
            ARM: begin
                if (!enable) begin
                    state_nx = IDLE;
                end else if (vs_rise && skip_cnt == '0) begin
                    state_nx  = PASS;
                    gate_open = 1'b1;
                end
            end
            PASS: begin
                gate_open = 1'b1;
                if (vs_fall) state_nx = PROC;
            end
            PROC: begin
                if (vid.finish_clear) state_nx = DONE;
                else if (timeout_hit) state_nx = enable ? ARM : IDLE;
            end
            DONE:    state_nx = enable ? ARM : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            vs_d       <= 1'b0;
            vid.vs_o   <= 1'b0;
            vid.hs_o   <= 1'b0;
            vid.de_o   <= 1'b0;
            vid.gray_o <= '0;
        end else begin
            vs_d       <= vid.vs_i;
            vid.vs_o   <= gate_open & vid.vs_i;
            vid.hs_o   <= gate_open & vid.hs_i;
            vid.de_o   <= gate_open & vid.de_i;
            vid.gray_o <= vid.gray_i;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            skip_cnt <= '0;
        end else if ((state == IDLE && enable) || state == DONE) begin
            skip_cnt <= cfg_skip;
        end else if (state == ARM && enable && vs_rise && skip_cnt != '0) begin
            skip_cnt <= skip_cnt - 4'd1;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cand_cnt <= '0;
            to_cnt   <= '0;
        end else if (proc_entry) begin
            cand_cnt <= '0;
            to_cnt   <= '0;
        end else if (state == PROC) begin
            to_cnt <= to_cnt + TO_W'(1);
            if (vid.dsp_vld) cand_cnt <= cand_cnt + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt   <= '0;
            err_count   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (state == DONE) frame_cnt <= frame_cnt + 16'd1;
            // Set has priority over clear.
            if (state == PROC && vid.finish_clear && cand_cnt != 8'(NUM_CAND))
                err_count <= 1'b1;
            else if (err_clr)
                err_count <= 1'b0;
            if (state == PROC && !vid.finish_clear && timeout_hit)
                err_timeout <= 1'b1;
            else if (err_clr)
                err_timeout <= 1'b0;
        end
    end

    assign busy         = (state == PASS) || (state == PROC);
    assign frame_done   = (state == DONE);
    assign vid.cand_vld = (state == PROC) && vid.dsp_vld;
    assign vid.cand_idx = cand_cnt[6:0];
endmodule

// File: tb/tb_otsu_frame_ctrl.sv
// Scoreboard bench for otsu_frame_ctrl: stimulus and the engine model push
// expected admissions, candidate indices and frame completions into queues;
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_otsu_frame_ctrl;
    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [3:0]  cfg_skip = 4'd0;
    logic        err_clr = 1'b0;
    logic        frame_done, busy, err_count, err_timeout;
    logic [15:0] frame_cnt;

    otsu_frame_ctrl_if vid();

    otsu_frame_ctrl #(.NUM_CAND(128), .TIMEOUT(20000), .TO_W(16)) dut (
        .clock(clock), .rst_n(rst_n), .enable(enable), .cfg_skip(cfg_skip),
        .err_clr(err_clr), .vid(vid), .frame_done(frame_done),
        .frame_cnt(frame_cnt), .busy(busy), .err_count(err_count),
        .err_timeout(err_timeout)
    );

    always #5 clock = ~clock;

    typedef struct {
        int fc;
        int ec;
        int cy;
    } done_t;

    int    n_vec = 0;
    int    n_bad = 0;
    int    cyc = 0;
    int    cand_q[$];
    int    id_q[$];
    done_t done_q[$];
    int    cur_id = 0;
    int    rise_cyc = 0;
    int    tb_fc = 0;
    int    exp_ec = 0;
    bit    eng_on = 1'b0;
    bit    eng_busy = 1'b0;
    int    eng_n = 128;
    int    eng_sp = 1;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_vs_o"}, vid.vs_o, 0);
        check({tag, "_hs_o"}, vid.hs_o, 0);
        check({tag, "_de_o"}, vid.de_o, 0);
        check({tag, "_gray_o"}, vid.gray_o, 0);
        check({tag, "_cand_vld"}, vid.cand_vld, 0);
        check({tag, "_cand_idx"}, vid.cand_idx, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_frame_cnt"}, frame_cnt, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err_count"}, err_count, 0);
        check({tag, "_err_timeout"}, err_timeout, 0);
    endtask

    // ---------------- monitor ----------------
    logic       hs_p = 1'b0, de_p = 1'b0;
    logic [7:0] gray_p = 8'd0;
    bit         mon_prev = 1'b0;
    bit         in_frame = 1'b0;
    int         m_exp;
    done_t      m_rec;

    always @(posedge clock) begin
        hs_p   <= vid.hs_i;
        de_p   <= vid.de_i;
        gray_p <= vid.gray_i;
    end

    always @(negedge clock) begin
        if (vid.vs_o && !mon_prev) begin
            if (id_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL vs_o_rise: frame %0d admitted, required blocked", cur_id);
            end else begin
                m_exp = id_q.pop_front();
                check("vs_o_frame_id", cur_id, m_exp);
                check("vs_o_latency", cyc - rise_cyc, 1);
                in_frame = 1'b1;
            end
        end
        if (!vid.vs_o && mon_prev) in_frame = 1'b0;
        mon_prev = vid.vs_o;
        check("hs_de_o", {vid.hs_o, vid.de_o}, in_frame ? {hs_p, de_p} : 2'b00);
        if (in_frame && vid.de_o) check("gray_o", vid.gray_o, gray_p);
        if (vid.cand_vld) begin
            if (cand_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL cand_vld: got idx %0d, required no strobe", vid.cand_idx);
            end else begin
                m_exp = cand_q.pop_front();
                check("cand_idx", vid.cand_idx, m_exp);
            end
        end
        if (frame_done) begin
            if (done_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL frame_done: got pulse, required none");
            end else begin
                m_rec = done_q.pop_front();
                check("done_frame_cnt", frame_cnt, m_rec.fc);
                check("done_err_count", err_count, m_rec.ec);
                check("done_latency", cyc - m_rec.cy, 1);
            end
        end
    end

    // ---------------- engine model ----------------
    initial begin
        bit    pe;
        done_t r;
        pe = 1'b0;
        forever begin
            @(negedge clock);
            if (eng_on && rst_n && pe && !vid.vs_o) begin
                eng_busy = 1'b1;
                for (int k = 0; k < eng_n; k++) begin
                    @(posedge clock); #1;
                    vid.dsp_vld = 1'b1;
                    cand_q.push_back(k % 128);
                    for (int s = 1; s < eng_sp; s++) begin
                        @(posedge clock); #1;
                        vid.dsp_vld = 1'b0;
                    end
                end
                @(posedge clock); #1;
                vid.dsp_vld = 1'b0;
                vid.finish_clear = 1'b1;
                if (eng_n != 128) exp_ec = 1;
                r.fc = tb_fc;
                r.ec = exp_ec;
                r.cy = cyc;
                done_q.push_back(r);
                tb_fc++;
                @(posedge clock); #1;
                vid.finish_clear = 1'b0;
                eng_busy = 1'b0;
            end
            pe = vid.vs_o;
        end
    end

    // ---------------- stimulus ----------------
    task automatic gap(input int n);
        repeat (n) @(posedge clock);
    endtask

    task automatic send_frame(input int id, input bit exp_pass, input bit en_mid, input bit rst_mid);
        @(posedge clock); #1;
        cur_id = id;
        vid.vs_i = 1'b1;
        rise_cyc = cyc;
        if (exp_pass) id_q.push_back(id);
        for (int l = 0; l < 4; l++) begin
            if (en_mid && l == 0) enable = 1'b1;
            for (int p = 0; p < 4; p++) begin
                @(posedge clock); #1;
                vid.hs_i = 1'b1;
                vid.de_i = 1'b1;
                vid.gray_i = 8'(id * 16 + l * 4 + p);
            end
            @(posedge clock); #1;
            vid.hs_i = 1'b0;
            vid.de_i = 1'b0;
            if (rst_mid && l == 1) begin
                check("pre_reset_vs_o", vid.vs_o, 1);
                #2 rst_n = 1'b0;
                #1 check_zero("mid_reset");
                tb_fc = 0;
                exp_ec = 0;
                #2 rst_n = 1'b1;
            end
        end
        @(posedge clock); #1;
        vid.vs_i = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30000; i++) begin
            @(negedge clock);
            if (!eng_busy && !busy && done_q.size() == 0 && cand_q.size() == 0) break;
        end
        check("wait_idle", {eng_busy, busy, 1'(done_q.size() != 0)}, 0);
    endtask

    initial begin
        int pc;
        vid.vs_i = 1'b0;
        vid.hs_i = 1'b0;
        vid.de_i = 1'b0;
        vid.gray_i = 8'd0;
        vid.dsp_vld = 1'b0;
        vid.finish_clear = 1'b0;
        repeat (3) @(posedge clock);
        #1 check_zero("reset");
        rst_n = 1'b1;
        enable = 1'b1;
        eng_on = 1'b1;

        // back-to-back frames, middle one lands during readout
        eng_n = 128; eng_sp = 1;
        send_frame(1, 1, 0, 0); gap(100);
        send_frame(2, 0, 0, 0); gap(100);
        send_frame(3, 1, 0, 0);
        wait_idle();
        check("t1_frame_cnt", frame_cnt, 2);
        check("t1_err_count", err_count, 0);
        check("t1_err_timeout", err_timeout, 0);

        // skip two frames between admissions
        cfg_skip = 4'd2;
        for (int f = 4; f <= 8; f++) begin
            send_frame(f, (f == 4 || f == 7), 0, 0);
            gap(200);
        end
        wait_idle();
        check("t2_frame_cnt", frame_cnt, 4);

        // reload skip=0, widely spaced candidate strobes
        enable = 1'b0; cfg_skip = 4'd0;
        gap(2);
        enable = 1'b1;
        gap(2);
        eng_sp = 128;
        send_frame(9, 1, 0, 0);
        wait_idle();

        // short count -> err_count, then clear
        eng_sp = 1; eng_n = 127;
        send_frame(10, 1, 0, 0);
        wait_idle();
        check("t4_err_count_set", err_count, 1);
        eng_n = 128;
        @(posedge clock); #1 err_clr = 1'b1;
        @(posedge clock); #1 err_clr = 1'b0;
        exp_ec = 0;
        #1 check("t4_err_count_clr", err_count, 0);

        // no finish_clear -> timeout after exactly 20000 PROC cycles
        eng_on = 1'b0;
        send_frame(11, 1, 0, 0);
        pc = 0;
        for (int k = 0; k < 25000; k++) begin
            @(negedge clock);
            if (!busy) break;
            if (!vid.vs_o) pc++;
        end
        check("t5_proc_cycles", pc, 20000);
        check("t5_err_timeout", err_timeout, 1);
        check("t5_frame_cnt", frame_cnt, tb_fc);
        eng_on = 1'b1;
        gap(3);
        send_frame(12, 1, 0, 0);
        wait_idle();
        check("t5_next_frame_cnt", frame_cnt, tb_fc);
        @(posedge clock); #1 err_clr = 1'b1;
        @(posedge clock); #1 err_clr = 1'b0;
        #1 check("t5_err_timeout_clr", err_timeout, 0);

        // enable rises mid-frame: partial frame never admitted
        enable = 1'b0;
        gap(2);
        send_frame(13, 0, 1, 0);
        gap(5);
        send_frame(14, 1, 0, 0);
        wait_idle();

        // asynchronous reset in the middle of an admitted frame
        eng_on = 1'b0;
        send_frame(15, 1, 0, 1);
        gap(3);
        eng_on = 1'b1;
        check("t6_frame_cnt_after_reset", frame_cnt, 0);
        send_frame(16, 1, 0, 0);
        wait_idle();
        check("t6_frame_cnt_final", frame_cnt, 1);
        check("cand_q_empty", cand_q.size(), 0);
        check("id_q_empty", id_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        n_vec++;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
